// File: rtl/array_pkg.sv
// Shared types and defaults for the systolic-array feeder slice.
package array_pkg;

  localparam int DEF_HEIGHT  = 4;
  localparam int DEF_IWIDTH  = 16;
  localparam int DEF_MAC_CYC = 16;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN
  } feed_state_t;

  typedef struct packed {
    logic en_i;
    logic clr_i;
    logic mac_done;
  } row_ctl_t;

endpackage

// File: rtl/array_ifm_feeder_if.sv
// Upstream vector handshake into the feeder; master is the producer, slave the feeder.
interface array_ifm_feeder_if #(
  parameter int HEIGHT = 4,
  parameter int IWIDTH = 16
);

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic signed [IWIDTH-1:0] in_ifm [HEIGHT];

  modport master (
    output in_valid,
    output in_last,
    output in_ifm,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  in_ifm,
    output in_ready
  );

endinterface

// File: rtl/skew_reg.sv
// DEPTH-stage delay line for one row's control bundle and ifm word; DEPTH=0 is a wire.
module skew_reg
  import array_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int IWIDTH = DEF_IWIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  row_ctl_t                 ctl,
  input  logic signed [IWIDTH-1:0] data,
  output row_ctl_t                 ctl_q,
  output logic signed [IWIDTH-1:0] data_q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign ctl_q  = ctl;
    assign data_q = data;
  end else begin : g_pipe
    row_ctl_t                 ctl_pipe  [DEPTH];
    logic signed [IWIDTH-1:0] data_pipe [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          ctl_pipe[i]  <= '0;
          data_pipe[i] <= '0;
        end
      end else begin
        ctl_pipe[0]  <= ctl;
        data_pipe[0] <= data;
        for (int i = 1; i < DEPTH; i++) begin
          ctl_pipe[i]  <= ctl_pipe[i-1];
          data_pipe[i] <= data_pipe[i-1];
        end
      end
    end

    assign ctl_q  = ctl_pipe[DEPTH-1];
    assign data_q = data_pipe[DEPTH-1];
  end

endmodule

// File: rtl/array_ifm_feeder.sv
// Holds each accepted ifm vector for MAC_CYC cycles and drives diagonally skewed
// row controls (en_i/clr_i/mac_done) and data into the systolic array.
module array_ifm_feeder
  import array_pkg::*;
#(
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int IWIDTH  = DEF_IWIDTH,
  parameter int MAC_CYC = DEF_MAC_CYC
) (
  input  logic                     clk,
  input  logic                     rst,
  array_ifm_feeder_if.slave        up,
  output logic signed [IWIDTH-1:0] ifm [HEIGHT],
  output logic [HEIGHT-1:0]        en_i,
  output logic [HEIGHT-1:0]        clr_i,
  output logic [HEIGHT-1:0]        mac_done,
  output logic                     busy
);

  localparam int            CW         = (MAC_CYC > 1) ? $clog2(MAC_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(MAC_CYC - 1);
  localparam int            DW         = (HEIGHT > 2) ? $clog2(HEIGHT - 1) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((HEIGHT > 1) ? HEIGHT - 2 : 0);

  feed_state_t              state;
  logic [CW-1:0]            cnt;
  logic [DW-1:0]            drain_cnt;
  logic                     hold_empty;
  logic                     lat_last;
  logic signed [IWIDTH-1:0] lat_ifm [HEIGHT];
  logic                     accept;
  logic                     final_hold;

  row_ctl_t                 row0_ctl;
  logic signed [IWIDTH-1:0] row0_ifm [HEIGHT];
  row_ctl_t                 row_ctl  [HEIGHT];

  assign final_hold  = (state == STREAM) && !hold_empty && (cnt == CNT_LAST);
  assign up.in_ready = !rst && ((state == IDLE) ||
                                ((state == STREAM) && hold_empty) ||
                                (final_hold && !lat_last));
  assign accept      = up.in_valid && up.in_ready;
  assign busy        = (state != IDLE);

  // Sequencing: one CLEAR per accumulation, then MAC_CYC-cycle holds chained
  // back-to-back, an empty-hold stall when upstream is late, and a drain that
  // lets the last vector ripple through the skew before going idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      drain_cnt  <= '0;
      hold_empty <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= CLEAR;
        end
        CLEAR: begin
          state      <= STREAM;
          cnt        <= '0;
          hold_empty <= 1'b0;
        end
        STREAM: begin
          if (hold_empty) begin
            if (accept) begin
              hold_empty <= 1'b0;
              cnt        <= '0;
            end
          end else if (cnt == CNT_LAST) begin
            if (lat_last) begin
              state     <= (HEIGHT > 1) ? DRAIN : IDLE;
              drain_cnt <= '0;
            end else if (accept) begin
              cnt <= '0;
            end else begin
              hold_empty <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= IDLE;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_last <= 1'b0;
      for (int h = 0; h < HEIGHT; h++) lat_ifm[h] <= '0;
    end else if (accept) begin
      lat_last <= up.in_last;
      for (int h = 0; h < HEIGHT; h++) lat_ifm[h] <= up.in_ifm[h];
    end
  end

  // Row 0 is decoded straight from the FSM registers; data is zeroed when idle.
  always_comb begin
    row0_ctl          = '0;
    row0_ctl.en_i     = (state == STREAM) && !hold_empty;
    row0_ctl.clr_i    = (state == CLEAR);
    row0_ctl.mac_done = final_hold;
    for (int h = 0; h < HEIGHT; h++) begin
      row0_ifm[h] = row0_ctl.en_i ? lat_ifm[h] : '0;
    end
  end

  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    skew_reg #(
      .DEPTH  (h),
      .IWIDTH (IWIDTH)
    ) u_skew (
      .clk    (clk),
      .rst    (rst),
      .ctl    (row0_ctl),
      .data   (row0_ifm[h]),
      .ctl_q  (row_ctl[h]),
      .data_q (ifm[h])
    );

    assign en_i[h]     = row_ctl[h].en_i;
    assign clr_i[h]    = row_ctl[h].clr_i;
    assign mac_done[h] = row_ctl[h].mac_done;
  end

endmodule
